// File: rtl/fsqrt_issue_ctrl.sv
// Issue/writeback sequencer for the FSQRT.D / FSQRT.S sqrt_fp units.
// Accepts one request from dispatch, unpacks NaN-boxed singles, drives the
// selected sqrt unit, NaN-boxes single results and returns them to writeback
// together with per-op flags and a sticky fflags accumulator.
//
// Handshake rule (both ports): a transfer happens on the rising edge where
// valid and ready are both 1. The source holds valid and its payload
// unchanged until that edge. req_ready depends only on state, and rsp_valid
// and rsp_* come straight from flops, so neither port has a combinational
// path from its input to its output.
module fsqrt_issue_ctrl #(
    parameter int          TagWidth   = 5,
    parameter logic [31:0] CanonNaN32 = 32'h7FC00000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [63:0]         req_operand,
    input  logic                req_is_single,
    input  logic [TagWidth-1:0] req_rd,
    output logic [63:0]         sqrt_operand,
    output logic                sqrt64_start,
    output logic                sqrt32_start,
    input  logic                sqrt64_done,
    input  logic                sqrt64_inexact,
    input  logic                sqrt64_invalid,
    input  logic [63:0]         sqrt64_result,
    input  logic                sqrt32_done,
    input  logic                sqrt32_inexact,
    input  logic                sqrt32_invalid,
    input  logic [31:0]         sqrt32_result,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [63:0]         rsp_data,
    output logic [TagWidth-1:0] rsp_rd,
    output logic [4:0]          rsp_flags,
    output logic [4:0]          fflags_acc,
    input  logic                fflags_clr,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [31:0] BoxOnes = 32'hFFFFFFFF;

    state_t                state_q, state_d;
    logic [63:0]           operand_q, operand_d;
    logic                  single_q, single_d;
    logic [TagWidth-1:0]   rd_q, rd_d;
    logic [63:0]           data_q, data_d;
    logic [4:0]            flags_q, flags_d;
    logic [4:0]            acc_q, acc_d;
    logic                  sel_done;
    logic                  rsp_fire;

    // Starts are decoded from state so an async reset drops them at once.
    assign req_ready    = (state_q == S_IDLE);
    assign rsp_valid    = (state_q == S_RESP);
    assign sqrt64_start = (state_q == S_BUSY) && !single_q;
    assign sqrt32_start = (state_q == S_BUSY) && single_q;
    assign sqrt_operand = operand_q;
    assign rsp_data     = data_q;
    assign rsp_rd       = rd_q;
    assign rsp_flags    = flags_q;
    assign fflags_acc   = acc_q;
    assign dbg_state    = state_q;

    assign sel_done = single_q ? sqrt32_done : sqrt64_done;
    assign rsp_fire = rsp_valid && rsp_ready;

    // Next-state, capture and flag-accumulation logic.
    always_comb begin
        state_d   = state_q;
        operand_d = operand_q;
        single_d  = single_q;
        rd_d      = rd_q;
        data_d    = data_q;
        flags_d   = flags_q;
        acc_d     = (fflags_clr ? 5'b00000 : acc_q) | (rsp_fire ? flags_q : 5'b00000);

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    single_d  = req_is_single;
                    rd_d      = req_rd;
                    // Singles only ever present their low word to the unit.
                    operand_d = req_is_single ? {32'h0, req_operand[31:0]} : req_operand;
                    if (req_is_single && (req_operand[63:32] != BoxOnes)) begin
                        // Improperly boxed single: answer with the canonical NaN.
                        data_d  = {BoxOnes, CanonNaN32};
                        flags_d = 5'b00000;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (sel_done) begin
                    if (single_q) begin
                        data_d  = {BoxOnes, sqrt32_result};
                        flags_d = {sqrt32_invalid, 3'b000, sqrt32_inexact};
                    end else begin
                        data_d  = sqrt64_result;
                        flags_d = {sqrt64_invalid, 3'b000, sqrt64_inexact};
                    end
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            operand_q <= '0;
            single_q  <= 1'b0;
            rd_q      <= '0;
            data_q    <= '0;
            flags_q   <= '0;
            acc_q     <= '0;
        end else begin
            state_q   <= state_d;
            operand_q <= operand_d;
            single_q  <= single_d;
            rd_q      <= rd_d;
            data_q    <= data_d;
            flags_q   <= flags_d;
            acc_q     <= acc_d;
        end
    end

endmodule

// File: tb/tb_fsqrt_issue_ctrl.sv
// Bench for fsqrt_issue_ctrl: stub sqrt units, directed scenarios and
// randomized ops checked against a per-operation reference model.
module tb_fsqrt_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [63:0] req_operand = '0;
    logic        req_is_single = 1'b0;
    logic [4:0]  req_rd = '0;
    logic [63:0] sqrt_operand;
    logic        sqrt64_start, sqrt32_start;
    logic        sqrt64_done = 1'b0, sqrt64_inexact = 1'b0, sqrt64_invalid = 1'b0;
    logic [63:0] sqrt64_result = '0;
    logic        sqrt32_done = 1'b0, sqrt32_inexact = 1'b0, sqrt32_invalid = 1'b0;
    logic [31:0] sqrt32_result = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic [4:0]  rsp_flags;
    logic [4:0]  fflags_acc;
    logic        fflags_clr = 1'b0;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    // Stub-unit controls and observations.
    int   lat64 = 1, lat32 = 1, cnt64 = 0, cnt32 = 0;
    logic spur64 = 1'b0, spur32 = 1'b0;
    logic seen64 = 1'b0, seen32 = 1'b0;
    logic [4:0] acc_model = '0;

    fsqrt_issue_ctrl #(.TagWidth(5), .CanonNaN32(32'h7FC00000)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_operand(req_operand),
        .req_is_single(req_is_single), .req_rd(req_rd),
        .sqrt_operand(sqrt_operand), .sqrt64_start(sqrt64_start), .sqrt32_start(sqrt32_start),
        .sqrt64_done(sqrt64_done), .sqrt64_inexact(sqrt64_inexact),
        .sqrt64_invalid(sqrt64_invalid), .sqrt64_result(sqrt64_result),
        .sqrt32_done(sqrt32_done), .sqrt32_inexact(sqrt32_inexact),
        .sqrt32_invalid(sqrt32_invalid), .sqrt32_result(sqrt32_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_rd(rsp_rd), .rsp_flags(rsp_flags), .fflags_acc(fflags_acc),
        .fflags_clr(fflags_clr), .dbg_state(dbg_state)
    );

    // Clock.
    always #5 clk = ~clk;

    // Stub units: done rises after lat falling edges of a held start; spur
    // injects a done regardless of start.
    always @(negedge clk) begin
        if (sqrt64_start) begin cnt64 = cnt64 + 1; seen64 = 1'b1; end else cnt64 = 0;
        if (sqrt32_start) begin cnt32 = cnt32 + 1; seen32 = 1'b1; end else cnt32 = 0;
        sqrt64_done = (sqrt64_start && cnt64 >= lat64) || spur64;
        sqrt32_done = (sqrt32_start && cnt32 >= lat32) || spur32;
    end

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || sqrt64_start !== 1'b0 ||
            sqrt32_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: req_ready=%b rsp_valid=%b s64=%b s32=%b, want 1 0 0 0",
                     req_ready, rsp_valid, sqrt64_start, sqrt32_start);
        end
        checks++;
        if (sqrt_operand !== 64'h0 || rsp_data !== 64'h0 || rsp_rd !== 5'h0 ||
            rsp_flags !== 5'h0 || fflags_acc !== 5'h0) begin
            errors++;
            $display("FAIL reset_data: opnd=%h data=%h rd=%h flags=%b acc=%b, want all 0",
                     sqrt_operand, rsp_data, rsp_rd, rsp_flags, fflags_acc);
        end
        reset = 1'b1;
        acc_model = '0;
    endtask

    // One full operation: request, unit stub, response with optional
    // backpressure and optional fflags_clr at the handshake.
    task automatic run_op(input logic [63:0] op, input logic single, input logic [4:0] rd,
                          input int lat, input logic [63:0] r64, input logic [31:0] r32,
                          input logic inx, input logic inv, input int bp,
                          input logic clr, input logic spur);
        logic        boxed;
        logic [63:0] e_data, e_opnd;
        logic [4:0]  e_flags;
        int          e_lat, cyc;
        logic        bad;

        // Reference model.
        boxed  = !single || (op[63:32] == 32'hFFFFFFFF);
        e_opnd = single ? {32'h0, op[31:0]} : op;
        if (!boxed) begin
            e_data  = {32'hFFFFFFFF, 32'h7FC00000};
            e_flags = 5'b00000;
            e_lat   = 1;
        end else begin
            e_data  = single ? {32'hFFFFFFFF, r32} : r64;
            e_flags = {inv, 3'b000, inx};
            e_lat   = lat + 1;
        end

        @(negedge clk);
        lat64 = lat; lat32 = lat;
        sqrt64_result = r64; sqrt32_result = r32;
        sqrt64_inexact = inx; sqrt32_inexact = inx;
        sqrt64_invalid = inv; sqrt32_invalid = inv;
        spur64 = spur && single; spur32 = spur && !single;
        seen64 = 1'b0; seen32 = 1'b0;
        req_valid = 1'b1; req_operand = op; req_is_single = single; req_rd = rd;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL req_ready_idle: got %b want 1", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_operand = {$urandom, $urandom};
        req_is_single = 1'($urandom_range(0, 1));
        req_rd = 5'($urandom);

        @(negedge clk);
        cyc = 1;
        if (boxed) begin
            checks++;
            if (sqrt_operand !== e_opnd) begin
                errors++;
                $display("FAIL sqrt_operand: got %h want %h", sqrt_operand, e_opnd);
            end
        end
        bad = 1'b0;
        while (!rsp_valid && cyc < 300) begin
            if (req_ready !== 1'b0) bad = 1'b1;
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL busy_ready: req_ready was 1 while busy, want 0");
        end
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL rsp_timeout: rsp_valid=%b after %0d cycles, want 1", rsp_valid, cyc);
        end else if (cyc != e_lat) begin
            errors++;
            $display("FAIL latency: got %0d cycles want %0d", cyc, e_lat);
        end
        checks++;
        if (rsp_data !== e_data || rsp_rd !== rd || rsp_flags !== e_flags) begin
            errors++;
            $display("FAIL rsp_payload: data=%h rd=%h flags=%b, want %h %h %b",
                     rsp_data, rsp_rd, rsp_flags, e_data, rd, e_flags);
        end
        checks++;
        if (seen64 !== (boxed && !single) || seen32 !== (boxed && single)) begin
            errors++;
            $display("FAIL start_select: seen64=%b seen32=%b, want %b %b",
                     seen64, seen32, boxed && !single, boxed && single);
        end

        // Backpressure: payload frozen, a new request is refused.
        if (bp > 0) begin
            bad = 1'b0;
            req_valid = 1'b1;
            repeat (bp) begin
                @(negedge clk);
                if (rsp_valid !== 1'b1 || rsp_data !== e_data || rsp_rd !== rd ||
                    rsp_flags !== e_flags || req_ready !== 1'b0) bad = 1'b1;
            end
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL backpressure: rsp_valid=%b data=%h req_ready=%b, want 1 %h 0",
                         rsp_valid, rsp_data, req_ready, e_data);
            end
        end

        rsp_ready = 1'b1;
        fflags_clr = clr;
        @(posedge clk);
        acc_model = (clr ? 5'b00000 : acc_model) | e_flags;
        #1;
        rsp_ready = 1'b0;
        fflags_clr = 1'b0;
        req_valid = 1'b0;
        spur64 = 1'b0; spur32 = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || sqrt64_start !== 1'b0 ||
            sqrt32_start !== 1'b0) begin
            errors++;
            $display("FAIL after_handshake: rsp_valid=%b req_ready=%b s64=%b s32=%b, want 0 1 0 0",
                     rsp_valid, req_ready, sqrt64_start, sqrt32_start);
        end
        checks++;
        if (fflags_acc !== acc_model) begin
            errors++;
            $display("FAIL fflags_acc: got %b want %b", fflags_acc, acc_model);
        end
    endtask

    task automatic test_double();
        run_op(64'h3FF1001000000000, 1'b0, 5'd3, 10, 64'h3FF07E1729882BBE, 32'h0,
               1'b1, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_boxed_single();
        run_op(64'hFFFFFFFF3F910208, 1'b1, 5'd7, 6, 64'h0, 32'h3F883D23,
               1'b0, 1'b0, 0, 1'b0, 1'b1);
    endtask

    task automatic test_unboxed_single();
        run_op(64'h000000003F910208, 1'b1, 5'd9, 4, 64'h0, 32'h12345678,
               1'b1, 1'b1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_sticky();
        run_op({32'hFFFFFFFF, 32'hC3290000}, 1'b1, 5'd1, 5, 64'h0, 32'hFFC00000,
               1'b0, 1'b1, 0, 1'b1, 1'b0);
        run_op(64'h3FF1001000000000, 1'b0, 5'd2, 3, 64'h3FF07E1729882BBE, 32'h0,
               1'b1, 1'b0, 0, 1'b0, 1'b0);
        checks++;
        if (fflags_acc !== 5'b10001) begin
            errors++;
            $display("FAIL sticky_acc: got %b want 10001", fflags_acc);
        end
        run_op(64'h4000000000000000, 1'b0, 5'd4, 2, 64'h3FF6A09E667F3BCD, 32'h0,
               1'b0, 1'b0, 0, 1'b1, 1'b0);
        checks++;
        if (fflags_acc !== 5'b00000) begin
            errors++;
            $display("FAIL clear_acc: got %b want 00000", fflags_acc);
        end
    endtask

    task automatic test_backpressure();
        run_op(64'hFFFFFFFF40800000, 1'b1, 5'd11, 3, 64'h0, 32'h40000000,
               1'b0, 1'b0, 5, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++)
            run_op({$urandom, $urandom}, 1'b0, 5'(i), 1, {$urandom, $urandom}, 32'h0,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        logic bad;
        @(negedge clk);
        lat64 = 30;
        req_valid = 1'b1; req_operand = 64'h3FF1001000000000; req_is_single = 1'b0; req_rd = 5'd5;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (sqrt64_start !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_busy: sqrt64_start=%b want 1", sqrt64_start);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (sqrt64_start !== 1'b0 || sqrt32_start !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_drop: s64=%b s32=%b rsp_valid=%b, want 0 0 0",
                     sqrt64_start, sqrt32_start, rsp_valid);
        end
        @(negedge clk);
        reset = 1'b1;
        acc_model = '0;
        spur64 = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (i == 3) spur64 = 1'b0;
            if (rsp_valid !== 1'b0 || sqrt64_start !== 1'b0 || req_ready !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL reset_mid_quiet: rsp_valid=%b s64=%b req_ready=%b, want 0 0 1",
                     rsp_valid, sqrt64_start, req_ready);
        end
    endtask

    task automatic test_random();
        logic [63:0] op;
        logic        single;
        for (int i = 0; i < 40; i++) begin
            op = {$urandom, $urandom};
            single = 1'($urandom_range(0, 1));
            if (single && $urandom_range(0, 3) != 0) op[63:32] = 32'hFFFFFFFF;
            run_op(op, single, 5'($urandom), $urandom_range(1, 8), {$urandom, $urandom},
                   $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3), $urandom_range(0, 7) == 0,
                   1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_double();
        test_boxed_single();
        test_unboxed_single();
        test_sticky();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
